// File: rtl/bist_pkg.sv
// +-----------------------------------------------------------------+
// | bist_pkg: shared state encoding and status words for the BIST   |
// | controller.                                         Rev 1.0     |
// +-----------------------------------------------------------------+
`default_nettype none

package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEED    = 3'd1,
    ST_RUN     = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [31:0] STATUS_IDLE = 32'h49444C45;
  localparam logic [31:0] STATUS_BUSY = 32'h42555359;
  localparam logic [31:0] STATUS_PASS = 32'h50415353;
  localparam logic [31:0] STATUS_FAIL = 32'h4641494C;

  localparam logic [7:0] DEFAULT_GOLDEN_SIG = 8'hDE;

endpackage

`default_nettype wire

// File: rtl/bist_pattern_counter.sv
// +-----------------------------------------------------------------+
// | bist_pattern_counter: saturating window counter with clear,     |
// | enable and terminal-count flag.                     Rev 1.0     |
// +-----------------------------------------------------------------+
`default_nettype none

module bist_pattern_counter #(
  parameter int CNT_W = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] count_next_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear has priority; the count never wraps past all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_next_o = count_d;
  assign tc_o         = (count_q == term_i);

endmodule

`default_nettype wire

// File: rtl/bist_controller.sv
// +-----------------------------------------------------------------+
// | bist_controller: sequences one BIST session (seed, run, flush,  |
// | compare) and reports the signature check.           Rev 1.0     |
// +-----------------------------------------------------------------+
`default_nettype none

module bist_controller
  import bist_pkg::*;
#(
  parameter int               PATTERN_COUNT = 256,
  parameter int               CNT_W         = 9,
  parameter int               LATENCY       = 2,
  parameter int               SIG_W         = 8,
  parameter logic [SIG_W-1:0] GOLDEN_SIG    = SIG_W'(DEFAULT_GOLDEN_SIG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] sig_in,
  output logic             test_sel,
  output logic             tpg_en,
  output logic             tpg_clr,
  output logic             misr_en,
  output logic             misr_clr,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [31:0]      status_word
);

  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(PATTERN_COUNT - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [CNT_W-1:0] MISR_START = CNT_W'(LATENCY);

  state_e state_q, state_d;

  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;
  logic [CNT_W-1:0] cnt_term;
  logic [CNT_W-1:0] cnt_d;

  logic        test_sel_q, test_sel_d;
  logic        tpg_en_q, tpg_en_d;
  logic        tpg_clr_q, tpg_clr_d;
  logic        misr_en_q, misr_en_d;
  logic        misr_clr_q, misr_clr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic [31:0] status_q, status_d;
  logic        aborting;

  assign cnt_term = (state_q == ST_FLUSH) ? FLUSH_LAST : RUN_LAST;

  bist_pattern_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk_i        (clk),
    .rst_ni       (rst),
    .clr_i        (cnt_clr),
    .en_i         (cnt_en),
    .term_i       (cnt_term),
    .count_next_o (cnt_d),
    .tc_o         (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEED;
          cnt_clr = 1'b1;
        end
      end
      ST_SEED: begin
        cnt_clr = 1'b1;
        state_d = abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          cnt_clr = 1'b1;
          state_d = (LATENCY > 0) ? ST_FLUSH : ST_COMPARE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          cnt_clr = 1'b1;
          state_d = ST_COMPARE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_COMPARE: begin
        cnt_clr = 1'b1;
        state_d = abort ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        if (!start) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  assign aborting = abort && (state_q inside {ST_SEED, ST_RUN, ST_FLUSH, ST_COMPARE});

  // Outputs are decoded from the next state so the flops line up with state_q.
  always_comb begin
    test_sel_d = (state_d inside {ST_SEED, ST_RUN, ST_FLUSH});
    tpg_en_d   = (state_d == ST_RUN);
    tpg_clr_d  = (state_d == ST_SEED);
    misr_clr_d = (state_d == ST_SEED);
    misr_en_d  = ((state_d == ST_RUN) && (cnt_d >= MISR_START)) || (state_d == ST_FLUSH);
    busy_d     = (state_d inside {ST_SEED, ST_RUN, ST_FLUSH, ST_COMPARE});
    done_d     = (state_d == ST_DONE);
    pass_d     = pass_q;
    fail_d     = fail_q;
    status_d   = status_q;
    if (aborting) begin
      pass_d   = 1'b0;
      fail_d   = 1'b0;
      status_d = STATUS_IDLE;
    end else if (state_d == ST_SEED) begin
      pass_d   = 1'b0;
      fail_d   = 1'b0;
      status_d = STATUS_BUSY;
    end else if (state_q == ST_COMPARE) begin
      pass_d   = (sig_in == GOLDEN_SIG);
      fail_d   = (sig_in != GOLDEN_SIG);
      status_d = (sig_in == GOLDEN_SIG) ? STATUS_PASS : STATUS_FAIL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      test_sel_q <= 1'b0;
      tpg_en_q   <= 1'b0;
      tpg_clr_q  <= 1'b0;
      misr_en_q  <= 1'b0;
      misr_clr_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      status_q   <= STATUS_IDLE;
    end else begin
      state_q    <= state_d;
      test_sel_q <= test_sel_d;
      tpg_en_q   <= tpg_en_d;
      tpg_clr_q  <= tpg_clr_d;
      misr_en_q  <= misr_en_d;
      misr_clr_q <= misr_clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      status_q   <= status_d;
    end
  end

  assign test_sel    = test_sel_q;
  assign tpg_en      = tpg_en_q;
  assign tpg_clr     = tpg_clr_q;
  assign misr_en     = misr_en_q;
  assign misr_clr    = misr_clr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign status_word = status_q;

endmodule

`default_nettype wire

// File: tb/tb_bist_controller.sv
// +-----------------------------------------------------------------+
// | tb_bist_controller: randomized self-checking bench for          |
// | bist_controller (default and LATENCY=0 builds).     Rev 1.0     |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_bist_controller;

  localparam logic [31:0] S_IDLE = 32'h49444C45;
  localparam logic [31:0] S_BUSY = 32'h42555359;
  localparam logic [31:0] S_PASS = 32'h50415353;
  localparam logic [31:0] S_FAIL = 32'h4641494C;
  localparam logic [7:0]  GOLD   = 8'hDE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a, abort_a, start_b, abort_b;
  logic [7:0] sig_a, sig_b;

  logic        ts_a, te_a, tc_a, me_a, mc_a, bz_a, dn_a, ps_a, fl_a;
  logic        ts_b, te_b, tc_b, me_b, mc_b, bz_b, dn_b, ps_b, fl_b;
  logic [31:0] st_a, st_b;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bist_controller u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .sig_in(sig_a),
    .test_sel(ts_a), .tpg_en(te_a), .tpg_clr(tc_a), .misr_en(me_a), .misr_clr(mc_a),
    .busy(bz_a), .done(dn_a), .pass(ps_a), .fail(fl_a), .status_word(st_a)
  );

  bist_controller #(.PATTERN_COUNT(4), .CNT_W(3), .LATENCY(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .sig_in(sig_b),
    .test_sel(ts_b), .tpg_en(te_b), .tpg_clr(tc_b), .misr_en(me_b), .misr_clr(mc_b),
    .busy(bz_b), .done(dn_b), .pass(ps_b), .fail(fl_b), .status_word(st_b)
  );

  wire [40:0] obs_a = {ts_a, te_a, tc_a, me_a, mc_a, bz_a, dn_a, ps_a, fl_a, st_a};
  wire [40:0] obs_b = {ts_b, te_b, tc_b, me_b, mc_b, bz_b, dn_b, ps_b, fl_b, st_b};

  // Expected outputs k cycles after start was sampled, from the phase lengths alone.
  function automatic logic [40:0] model(input int k, input int pc, input int lat,
                                        input logic [7:0] sig);
    logic seed, run, flush, cmp, dn, good, men;
    logic [31:0] st;
    seed  = (k == 0);
    run   = (k >= 1) && (k <= pc);
    flush = (k > pc) && (k <= pc + lat);
    cmp   = (k == pc + lat + 1);
    dn    = (k >= pc + lat + 2);
    men   = (k > lat) && (k <= pc + lat);
    good  = (sig == GOLD);
    st    = dn ? (good ? S_PASS : S_FAIL) : S_BUSY;
    return {seed | run | flush, run, seed, men, seed, seed | run | flush | cmp, dn,
            dn & good, dn & ~good, st};
  endfunction

  task automatic drive(input bit on_b, input logic s, input logic a, input logic [7:0] g);
    if (on_b) begin
      start_b = s; abort_b = a; sig_b = g;
    end else begin
      start_a = s; abort_a = a; sig_a = g;
    end
  endtask

  // Runs one session from IDLE; abort_k >= 0 aborts in the cycle k cycles after start.
  task automatic test_session(input bit on_b, input logic [7:0] sig_val, input int abort_k,
                              input int hold, input logic abort_on_start);
    int pc, lat, last;
    logic s, a;
    logic [7:0] g;
    logic [40:0] exp, got;
    pc   = on_b ? 4 : 256;
    lat  = on_b ? 0 : 2;
    last = (abort_k >= 0) ? abort_k + 1 : pc + lat + 2 + hold;
    s = 1'b1;
    drive(on_b, 1'b1, abort_on_start, 8'($urandom));
    for (int k = 0; k <= last; k++) begin
      @(posedge clk);
      @(negedge clk);
      got = on_b ? obs_b : obs_a;
      if ((abort_k >= 0) && (k == abort_k + 1)) exp = {7'b0, 2'b00, S_IDLE};
      else exp = model(k, pc, lat, sig_val);
      checks++;
      if (got !== exp)
        $display("FAIL session%s k=%0d sig=%h: observed %h expected %h",
                 on_b ? "_b" : "_a", k, sig_val, got, exp);
      else passed++;
      a = (k == abort_k) ? 1'b1 : ((k >= pc + lat + 2) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (k == abort_k) s = 1'b0;
      g = (k == pc + lat + 1) ? sig_val : 8'($urandom);
      drive(on_b, s, a, g);
    end
    drive(on_b, 1'b0, 1'b0, 8'($urandom));
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      @(negedge clk);
      got = on_b ? obs_b : obs_a;
      if (abort_k >= 0) exp = {7'b0, 2'b00, S_IDLE};
      else exp = {7'b0, sig_val == GOLD, sig_val != GOLD, (sig_val == GOLD) ? S_PASS : S_FAIL};
      checks++;
      if (got !== exp)
        $display("FAIL idle_after%s j=%0d: observed %h expected %h",
                 on_b ? "_b" : "_a", j, got, exp);
      else passed++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs_a !== {7'b0, 2'b00, S_IDLE})
      $display("FAIL reset_a: observed %h expected %h", obs_a, {7'b0, 2'b00, S_IDLE});
    else passed++;
    checks++;
    if (obs_b !== {7'b0, 2'b00, S_IDLE})
      $display("FAIL reset_b: observed %h expected %h", obs_b, {7'b0, 2'b00, S_IDLE});
    else passed++;
    rst = 1'b1;
  endtask

  task automatic test_pass();
    test_session(1'b0, GOLD, -1, 0, 1'b0);
  endtask

  task automatic test_fail();
    test_session(1'b0, 8'h21, -1, 0, 1'b0);
  endtask

  task automatic test_abort();
    test_session(1'b0, GOLD, 101, 0, 1'b0);
    test_session(1'b0, GOLD, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_session(1'b0, GOLD, -1, 6, 1'b1);
    test_session(1'b0, 8'h5A, -1, 2, 1'b0);
  endtask

  task automatic test_lat0();
    test_session(1'b1, GOLD, -1, 2, 1'b0);
    test_session(1'b1, 8'h21, -1, 0, 1'b1);
    test_session(1'b1, GOLD, 3, 0, 1'b0);
  endtask

  task automatic test_async_reset();
    int seen_done;
    seen_done = 0;
    drive(1'b0, 1'b1, 1'b0, GOLD);
    for (int k = 0; k <= 150; k++) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs_a !== {7'b0, 2'b00, S_IDLE})
      $display("FAIL async_reset: observed %h expected %h", obs_a, {7'b0, 2'b00, S_IDLE});
    else passed++;
    drive(1'b0, 1'b0, 1'b0, GOLD);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (dn_a || bz_a) seen_done++;
    end
    checks++;
    if (seen_done != 0)
      $display("FAIL no_done_after_reset: observed %0d active cycles required 0", seen_done);
    else passed++;
  endtask

  task automatic test_random();
    logic [7:0] sv;
    int ak, pc_lat;
    for (int n = 0; n < 8; n++) begin
      bit on_b;
      on_b   = (n % 4 == 3);
      pc_lat = on_b ? 4 : 258;
      sv     = ($urandom_range(0, 1) == 1) ? GOLD : 8'($urandom);
      ak     = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, pc_lat + 1)) : -1;
      test_session(on_b, sv, ak, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    start_a = 1'b0; abort_a = 1'b0; sig_a = 8'h00;
    start_b = 1'b0; abort_b = 1'b0; sig_b = 8'h00;
    #1 rst = 1'b0;
    test_reset();
    @(negedge clk);
    test_pass();
    test_fail();
    test_abort();
    test_back_to_back();
    test_lat0();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
